otter_iobus_uart_tx: RTL and testbench

Memory-mapped IOBUS responder for the pipelined OTTER CPU. It decodes CPU stores and loads on IOBUS_ADDR, IOBUS_OUT, IOBUS_WR and IOBUS_IN, buffers transmit bytes in a small FIFO, and serialises them as 8N1 UART frames. It also raises a level interrupt toward the CPU INTR input when transmission completes.

---
 rtl/otter_iobus_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_otter_iobus_uart_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_iobus_uart_tx.sv
// otter_iobus_uart_tx
// IOBUS-mapped UART transmitter for the OTTER CPU. CPU stores to TXDATA
// fill a small circular FIFO; a shifter drains it as 8N1 frames on TX.
// A level interrupt reports "everything sent" when enabled.
//
// Register window (offset = IOBUS_ADDR[3:2]):
//   0 TXDATA  W: push byte         R: 0
//   1 STATUS  R: {count, ovf, empty, full, busy}   W: bit3=1 clears ovf
//   2 CTRL    RW: bit0 irq_en
//   3 DIV     RW: clocks per bit (0 is stored as 1)
//
// Shifter states:
//   state    | meaning
//   ST_IDLE  | line high, pops the FIFO head when data is waiting
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first, shifting at each period end
//   ST_STOP  | stop bit (high) for one bit period, then back to idle
module otter_iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR,
    output logic        TX
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_DIV    = 2'd3;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       count;
    logic             overflow;
    logic             irq_en;
    logic [15:0]      div_reg;

    logic [1:0]       state;
    logic [7:0]       shift_reg;
    logic [15:0]      bit_div;
    logic [15:0]      cyc_cnt;
    logic [2:0]       bit_cnt;
    logic             intr_reg;

    logic             addr_hit;
    logic [1:0]       reg_off;
    logic             wr_en;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             busy;
    logic             period_end;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign addr_hit   = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign reg_off    = IOBUS_ADDR[3:2];
    assign wr_en      = IOBUS_WR & addr_hit;
    assign push       = wr_en & (reg_off == OFF_TXDATA);
    assign fifo_full  = (count == 5'(FIFO_DEPTH));
    assign fifo_empty = (count == 5'd0);
    // A full FIFO drops the byte even if the shifter pops in the same cycle.
    assign push_ok    = push & ~fifo_full;
    assign pop        = (state == ST_IDLE) & ~fifo_empty;
    assign busy       = (state != ST_IDLE);
    assign period_end = (cyc_cnt == bit_div - 16'd1);

    assign status_word = {23'd0, count, overflow, fifo_empty, fifo_full, busy};
    assign INTR        = intr_reg;

    // Byte lane and high half of DIV-sized stores are don't-care bits.
    assign unused_bits = &{1'b0, IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (push & fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_en && reg_off == OFF_STATUS && IOBUS_OUT[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Control and divisor registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_en  <= 1'b0;
            div_reg <= DIV_RESET;
        end else if (wr_en) begin
            if (reg_off == OFF_CTRL) begin
                irq_en <= IOBUS_OUT[0];
            end
            if (reg_off == OFF_DIV) begin
                div_reg <= (IOBUS_OUT[15:0] == 16'd0) ? 16'd1 : IOBUS_OUT[15:0];
            end
        end
    end

    // Shifter FSM; DIV is latched per frame so mid-frame writes wait a frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            shift_reg <= 8'd0;
            bit_div   <= DIV_RESET;
            cyc_cnt   <= 16'd0;
            bit_cnt   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        bit_div   <= div_reg;
                        cyc_cnt   <= 16'd0;
                        bit_cnt   <= 3'd0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (period_end) begin
                        cyc_cnt <= 16'd0;
                        state   <= ST_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (period_end) begin
                        cyc_cnt   <= 16'd0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                default: begin
                    if (period_end) begin
                        cyc_cnt <= 16'd0;
                        state   <= ST_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Registered "all sent" interrupt.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            intr_reg <= 1'b0;
        end else begin
            intr_reg <= irq_en & fifo_empty & ~busy;
        end
    end

    // Line level decoded from the shifter state.
    always_comb begin
        TX = 1'b1;
        case (state)
            ST_START: TX = 1'b0;
            ST_DATA:  TX = shift_reg[0];
            default:  TX = 1'b1;
        endcase
    end

    // Combinational read-back, zero on address miss.
    always_comb begin
        IOBUS_IN = 32'd0;
        if (addr_hit) begin
            case (reg_off)
                OFF_STATUS: IOBUS_IN = status_word;
                OFF_CTRL:   IOBUS_IN = {31'd0, irq_en};
                OFF_DIV:    IOBUS_IN = {16'd0, div_reg};
                default:    IOBUS_IN = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Testbench for otter_iobus_uart_tx: scenario tasks plus a TX frame monitor
// that decodes every frame and checks it against a queue of expected bytes.
module tb_otter_iobus_uart_tx;

    localparam logic [31:0] BASE   = 32'h1100_0100;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_DIV  = BASE + 32'hC;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'd0;
    logic [31:0] IOBUS_OUT = 32'd0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        INTR;
    logic        TX;

    int vectors = 0;
    int miscompares = 0;
    int cur_div = 868;
    int frames_done = 0;
    logic [7:0] sb[$];

    otter_iobus_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd868)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .INTR      (INTR),
        .TX        (TX)
    );

    always #5 CLK = ~CLK;

    // Frame monitor: hunts for a start bit, samples all 10*div cycles.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] exp_b;
        logic       has_exp;
        logic       stable;
        logic       aborted;
        int         d;
        forever begin
            @(negedge CLK);
            if (!RESET && TX === 1'b0) begin
                d = cur_div;
                has_exp = 1'b0;
                exp_b = 8'h00;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got start bit at %0t, required no frame", $time);
                end else begin
                    exp_b = sb.pop_front();
                    has_exp = 1'b1;
                end
                stable = 1'b1;
                aborted = 1'b0;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < d; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge CLK);
                        if (RESET) aborted = 1'b1;
                        if (aborted) break;
                        if (c == 0) bits[b] = TX;
                        else if (TX !== bits[b]) stable = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted && has_exp) begin
                    vectors++;
                    if (bits[8:1] !== exp_b || bits[9] !== 1'b1 || stable !== 1'b1) begin
                        miscompares++;
                        $display("FAIL frame: got data %h stop %b stable %b, required data %h stop 1 stable 1",
                                 bits[8:1], bits[9], stable, exp_b);
                    end
                    frames_done++;
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'd0;
        IOBUS_OUT  = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
    endtask

    task automatic set_div(input logic [31:0] d);
        bus_write(A_DIV, d);
        cur_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus_write(A_TX, {24'd0, b});
        if (accepted) sb.push_back(b);
    endtask

    task automatic wait_drain(input int max_cyc);
        logic [31:0] st;
        int n;
        n = 0;
        bus_read(A_ST, st);
        while ((st !== 32'h4 || sb.size() != 0) && n < max_cyc) begin
            @(posedge CLK);
            #1;
            bus_read(A_ST, st);
            n++;
        end
        if (n >= max_cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got status %h queue %0d, required status 00000004 queue 0", st, sb.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin miscompares++; $display("FAIL reset_status: got %h required 00000004", rd); end
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_ctrl: got %h required 00000000", rd); end
        @(posedge CLK); #1;
        bus_read(A_DIV, rd);
        vectors++;
        if (rd !== 32'd868) begin miscompares++; $display("FAIL reset_div: got %0d required 868", rd); end
        bus_read(A_TX, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL read_txdata: got %h required 00000000", rd); end
        @(posedge CLK); #1;
        bus_read(BASE + 32'h10, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL read_miss: got %h required 00000000", rd); end
        bus_read(BASE + 32'h6, rd);
        vectors++;
        if (rd !== 32'h4) begin miscompares++; $display("FAIL status_lowbits_ignored: got %h required 00000004", rd); end
        vectors++;
        if (TX !== 1'b1 || INTR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lines: got TX=%b INTR=%b required TX=1 INTR=0", TX, INTR);
        end
    endtask

    task automatic test_div_write();
        logic [31:0] rd;
        set_div(32'd0);
        bus_read(A_DIV, rd);
        vectors++;
        if (rd !== 32'd1) begin miscompares++; $display("FAIL div_zero: got %0d required 1", rd); end
        bus_write(BASE + 32'h1C, 32'd77);
        bus_read(A_DIV, rd);
        vectors++;
        if (rd !== 32'd1) begin miscompares++; $display("FAIL miss_write: got %0d required 1", rd); end
        set_div(32'hABCD_0009);
        bus_read(A_DIV, rd);
        vectors++;
        if (rd !== 32'd9) begin miscompares++; $display("FAIL div_upper_ignored: got %h required 00000009", rd); end
    endtask

    task automatic test_single_frame();
        int exp_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [31:0] rd;
        set_div(32'd4);
        push_byte(8'hA5, 1'b1);
        IOBUS_ADDR = A_ST;
        @(posedge CLK);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            vectors++;
            if (TX !== exp_seq[i / 4][0] || IOBUS_IN[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_a5 cycle %0d: got TX=%b busy=%b required TX=%0d busy=1",
                         i, TX, IOBUS_IN[0], exp_seq[i / 4]);
            end
        end
        @(posedge CLK); #1;
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h4) begin miscompares++; $display("FAIL busy_after_frame: got %h required 00000004", rd); end
        wait_drain(200);
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        set_div(32'd2);
        push_byte(8'h3C, 1'b1);
        @(posedge CLK); #1;
        for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i), i < 8);
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h0000_008B) begin miscompares++; $display("FAIL overflow_status: got %h required 0000008b", rd); end
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h0000_0083) begin miscompares++; $display("FAIL overflow_clear: got %h required 00000083", rd); end
        wait_drain(1000);
    endtask

    task automatic test_back_to_back_intr();
        logic [31:0] rd;
        int cyc;
        set_div(32'd2);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd);
        vectors++;
        if (rd !== 32'h1) begin miscompares++; $display("FAIL ctrl_read: got %h required 00000001", rd); end
        push_byte(8'h00, 1'b1);
        vectors++;
        if (INTR !== 1'b1) begin miscompares++; $display("FAIL intr_rise_idle: got %b required 1", INTR); end
        push_byte(8'hFF, 1'b1);
        vectors++;
        if (INTR !== 1'b0) begin miscompares++; $display("FAIL intr_clear_on_push: got %b required 0", INTR); end
        cyc = 0;
        while (INTR !== 1'b1 && cyc < 300) begin
            @(posedge CLK); #1;
            cyc++;
        end
        vectors++;
        if (cyc !== 42) begin miscompares++; $display("FAIL b2b_intr_latency: got %0d cycles required 42", cyc); end
        push_byte(8'h5A, 1'b1);
        vectors++;
        if (INTR !== 1'b1) begin miscompares++; $display("FAIL intr_hold_push_edge: got %b required 1", INTR); end
        @(posedge CLK); #1;
        vectors++;
        if (INTR !== 1'b0) begin miscompares++; $display("FAIL intr_drop_after_push: got %b required 0", INTR); end
        wait_drain(200);
        @(posedge CLK); #1;
        vectors++;
        if (INTR !== 1'b1) begin miscompares++; $display("FAIL intr_after_drain: got %b required 1", INTR); end
        bus_write(A_CTRL, 32'h0);
        @(posedge CLK); #1;
        vectors++;
        if (INTR !== 1'b0) begin miscompares++; $display("FAIL intr_irq_en_off: got %b required 0", INTR); end
    endtask

    task automatic test_fifo_wrap();
        logic [31:0] rd;
        int start_frames;
        int n;
        set_div(32'd2);
        start_frames = frames_done;
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h0000_0011) begin miscompares++; $display("FAIL push_pop_same_cycle: got %h required 00000011", rd); end
        for (int i = 0; i < 18; i++) begin
            n = 0;
            bus_read(A_ST, rd);
            while (rd[1] === 1'b1 && n < 100) begin
                @(posedge CLK); #1;
                bus_read(A_ST, rd);
                n++;
            end
            push_byte(8'(i * 37 + 5), 1'b1);
        end
        wait_drain(2000);
        vectors++;
        if (frames_done - start_frames !== 20) begin
            miscompares++;
            $display("FAIL wrap_frame_count: got %0d required 20", frames_done - start_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int bad;
        set_div(32'd4);
        for (int i = 0; i < 4; i++) push_byte(8'(i), 1'b1);
        repeat (4) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        vectors++;
        if (TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx_immediate: got %b required 1", TX); end
        bus_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h4) begin miscompares++; $display("FAIL reset_mid_status: got %h required 00000004", rd); end
        cur_div = 868;
        @(posedge CLK); #1;
        RESET = 1'b0;
        sb.delete();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL no_frame_after_reset: got %0d low cycles required 0", bad); end
        @(posedge CLK); #1;
        bus_read(A_DIV, rd);
        vectors++;
        if (rd !== 32'd868) begin miscompares++; $display("FAIL reset_mid_div: got %0d required 868", rd); end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        test_reset();
        test_div_write();
        test_single_frame();
        test_overflow();
        test_back_to_back_intr();
        test_fifo_wrap();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
